// File: rtl/nic_access_ctrl.sv
// nic_access_ctrl: round-robin RX/TX sequencer between the PE and the NIC register port, with a local RX FIFO.
// Optional 16-bit saturating traffic counters when NIC_ACCESS_CTRL_STATS_EN is defined.
module nic_access_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int RX_DEPTH   = 4,
  parameter int STAT_BIT   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_valid,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_ready,
  output logic                      rx_valid,
  output logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      nicEn,
  output logic                      nicWrEN,
  output logic [1:0]                addr,
  output logic [DATA_WIDTH-1:0]     d_in,
  input  logic [DATA_WIDTH-1:0]     d_out
`ifdef NIC_ACCESS_CTRL_STATS_EN
  ,
  output logic [15:0]               rx_pkt_cnt,
  output logic [15:0]               tx_pkt_cnt,
  output logic [15:0]               busy_retry_cnt
`endif
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, RX_STAT, RX_SWAIT, RX_READ, RX_RWAIT, TX_STAT, TX_SWAIT, TX_WRITE
  } state_e;

  state_e                state_q, state_d;
  logic                  last_tx_q, last_tx_d;
  logic                  nic_en_q, nic_en_d;
  logic [1:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mem_q [RX_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  rx_cand, grant_rx, grant_tx, stat, push, pop, tx_go;

  assign rx_cand  = cnt_q < CW'(RX_DEPTH);
  assign grant_rx = rx_cand && (!tx_valid || last_tx_q);
  assign grant_tx = tx_valid && (!rx_cand || !last_tx_q);
  assign stat     = d_out[STAT_BIT];
  assign push     = state_q == RX_RWAIT;
  assign pop      = rx_ready && rx_valid;
  // The write strobe follows tx_valid live so a withdrawn packet never reaches the NIC
  assign tx_go    = (state_q == TX_WRITE) && tx_valid;

  always_comb begin
    state_d   = state_q;
    last_tx_d = last_tx_q;
    unique case (state_q)
      IDLE: begin
        state_d   = grant_rx ? RX_STAT : grant_tx ? TX_STAT : IDLE;
        last_tx_d = grant_rx ? 1'b0 : grant_tx ? 1'b1 : last_tx_q;
      end
      RX_STAT:  state_d = RX_SWAIT;
      RX_SWAIT: state_d = stat ? RX_READ : IDLE;
      RX_READ:  state_d = RX_RWAIT;
      RX_RWAIT: state_d = IDLE;
      TX_STAT:  state_d = TX_SWAIT;
      TX_SWAIT: state_d = stat ? IDLE : TX_WRITE;
      TX_WRITE: state_d = IDLE;
    endcase
    nic_en_d = state_d inside {RX_STAT, RX_READ, TX_STAT};
    addr_d   = state_d == RX_STAT ? 2'b01 : state_d == TX_STAT ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_tx_q <= 1'b1;
      nic_en_q  <= 1'b0;
      addr_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_tx_q <= last_tx_d;
      nic_en_q  <= nic_en_d;
      addr_q    <= addr_d;
    end
  end

  assign nicEn    = nic_en_q | tx_go;
  assign nicWrEN  = tx_go;
  assign addr     = tx_go ? 2'b10 : addr_q;
  assign d_in     = tx_go ? tx_data : '0;
  assign tx_ready = tx_go;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= d_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push ? wr_q + AW'(1) : wr_q;
      rd_q  <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign rx_valid = cnt_q != '0;
  assign rx_data  = rx_valid ? mem_q[rd_q] : '0;
  assign rx_count = cnt_q;

`ifdef NIC_ACCESS_CTRL_STATS_EN
  logic [15:0] rx_pkt_q, tx_pkt_q, retry_q;
  logic        retry;

  assign retry = (state_q == TX_SWAIT) && stat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_pkt_q <= '0;
      tx_pkt_q <= '0;
      retry_q  <= '0;
    end else begin
      rx_pkt_q <= (push && rx_pkt_q != 16'hFFFF) ? rx_pkt_q + 16'd1 : rx_pkt_q;
      tx_pkt_q <= (tx_go && tx_pkt_q != 16'hFFFF) ? tx_pkt_q + 16'd1 : tx_pkt_q;
      retry_q  <= (retry && retry_q != 16'hFFFF) ? retry_q + 16'd1 : retry_q;
    end
  end

  assign rx_pkt_cnt     = rx_pkt_q;
  assign tx_pkt_cnt     = tx_pkt_q;
  assign busy_retry_cnt = retry_q;
`endif
endmodule
